// File: rtl/pl_inv_iter.sv
// Iterative inverse of the Ascon pl diffusion layer: six commuting rotate-XOR stages under start/done.
// Optional PL_INV_UNROLL2_EN applies two stages per clock (3-cycle latency); results are identical.
package ascon_pack;
  typedef logic [4:0][63:0] type_state;
endpackage

module pl_inv_iter
  import ascon_pack::*;
(
  input  logic      clock_i,
  input  logic      resetb_i,
  input  logic      start_i,
  input  type_state pl_inv_i,
  output type_state pl_inv_o,
  output logic      busy_o,
  output logic      done_o
);

  localparam logic [4:0][5:0] ROT_A = {6'd7,  6'd10, 6'd1, 6'd61, 6'd19};
  localparam logic [4:0][5:0] ROT_B = {6'd41, 6'd17, 6'd6, 6'd39, 6'd28};

`ifdef PL_INV_UNROLL2_EN
  localparam logic [2:0] K_STEP = 3'd2;
  localparam logic [2:0] K_LAST = 3'd4;
`else
  localparam logic [2:0] K_STEP = 3'd1;
  localparam logic [2:0] K_LAST = 3'd5;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t     fsm_q;
  logic [2:0] k_q;
  type_state  state_q;
  type_state  state_d;
  type_state  src;
  logic       busy_q;
  logic       done_q;

  function automatic logic [63:0] ror64(input logic [63:0] x, input logic [5:0] r);
    logic [127:0] xx;
    xx = {x, x} >> r;
    return xx[63:0];
  endfunction

  // Amounts a*2^k and b*2^k wrap mod 64 by truncation to 6 bits; a zero amount cancels naturally.
  function automatic type_state stage(input type_state x, input logic [2:0] k);
    type_state  y;
    logic [5:0] ra;
    logic [5:0] rb;
    y = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      ra   = ROT_A[i] << k;
      rb   = ROT_B[i] << k;
      y[i] = x[i] ^ ror64(x[i], ra) ^ ror64(x[i], rb);
    end
    return y;
  endfunction

  always_comb begin
    src = (fsm_q == ST_IDLE) ? pl_inv_i : state_q;
`ifdef PL_INV_UNROLL2_EN
    state_d = stage(stage(src, k_q), k_q + 3'd1);
`else
    state_d = stage(src, k_q);
`endif
  end

  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      fsm_q   <= ST_IDLE;
      k_q     <= '0;
      state_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (fsm_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= state_d;
            k_q     <= K_STEP;
            busy_q  <= 1'b1;
            fsm_q   <= ST_RUN;
          end
        end
        ST_RUN: begin
          state_q <= state_d;
          k_q     <= k_q + K_STEP;
          if (k_q == K_LAST) begin
            k_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            fsm_q  <= ST_DONE;
          end
        end
        ST_DONE: fsm_q <= ST_IDLE;
        default: fsm_q <= ST_IDLE;
      endcase
    end
  end

  assign pl_inv_o = state_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_pl_inv_iter.sv
// Scoreboard bench for pl_inv_iter: forward pl model generates inputs, monitor checks results on done_o.
module tb_pl_inv_iter;
  import ascon_pack::*;

`ifdef PL_INV_UNROLL2_EN
  localparam int unsigned LAT    = 3;
  localparam int unsigned RST_AT = 1;
`else
  localparam int unsigned LAT    = 6;
  localparam int unsigned RST_AT = 3;
`endif

  typedef struct {
    type_state   x;
    type_state   din;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetb;
  logic        start;
  type_state   din;
  type_state   dout;
  logic        busy;
  logic        done;

  int unsigned cyc = 0;
  int unsigned model_free = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];

  pl_inv_iter dut (
    .clock_i  (clk),
    .resetb_i (resetb),
    .start_i  (start),
    .pl_inv_i (din),
    .pl_inv_o (dout),
    .busy_o   (busy),
    .done_o   (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] rr(input logic [63:0] v, input int unsigned r);
    return (v >> r) | (v << (64 - r));
  endfunction

  function automatic type_state pl_fwd(input type_state x);
    type_state y;
    y[0] = x[0] ^ rr(x[0], 19) ^ rr(x[0], 28);
    y[1] = x[1] ^ rr(x[1], 61) ^ rr(x[1], 39);
    y[2] = x[2] ^ rr(x[2], 1)  ^ rr(x[2], 6);
    y[3] = x[3] ^ rr(x[3], 10) ^ rr(x[3], 17);
    y[4] = x[4] ^ rr(x[4], 7)  ^ rr(x[4], 41);
    return y;
  endfunction

  function automatic type_state rand_state();
    type_state r;
    for (int i = 0; i < 5; i++) r[i] = {$urandom, $urandom};
    return r;
  endfunction

  task automatic chk_st(input string name, input type_state got, input type_state want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
    end
  endtask

  // Monitor: every done_o pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done cyc=%0d got done_o=1 want no pulse", cyc);
      end else begin
        e = sb.pop_front();
        chk_st("result", dout, e.x);
        chk_st("roundtrip_pl", pl_fwd(dout), e.din);
        chk_int("busy_at_done", int'(busy), 0);
        chk_int("latency", int'(cyc - e.cyc), int'(LAT));
      end
    end
  end

  task automatic wait_free();
    while (cyc < model_free) @(negedge clk);
  endtask

  task automatic run_op(input type_state x, input bit chk_busy);
    exp_t e;
    @(negedge clk);
    wait_free();
    start = 1'b1;
    din   = pl_fwd(x);
    e.x   = x;
    e.din = din;
    e.cyc = cyc;
    sb.push_back(e);
    model_free = cyc + LAT + 1;
    @(negedge clk);
    start = 1'b0;
    din   = rand_state();
    if (chk_busy) chk_int("busy_after_accept", int'(busy), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    type_state xv;
    type_state zero_s;
    type_state ones_s;
    exp_t      e;
    int unsigned c0;

    zero_s = '0;
    ones_s = '1;
    xv[0]  = 64'h80400c0600000000;
    xv[1]  = 64'h0001020304050607;
    xv[2]  = 64'h08090a0b0c0d0eff;
    xv[3]  = 64'h0011223344556677;
    xv[4]  = 64'h8899aabbccddeeff;

    resetb = 1'b0;
    start  = 1'b0;
    din    = rand_state();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_st("reset_out", dout, zero_s);
    chk_int("reset_busy", int'(busy), 0);
    chk_int("reset_done", int'(done), 0);
    resetb = 1'b1;
    model_free = cyc;
    @(negedge clk);
    chk_int("idle_after_reset_busy", int'(busy), 0);
    chk_st("idle_after_reset_out", dout, zero_s);

    run_op(zero_s, 1'b1);
    run_op(ones_s, 1'b1);
    run_op(xv, 1'b1);

    for (int n = 0; n < 1000; n++) run_op(rand_state(), 1'b0);

    // start_i held high: only cycles where the pipeline is free accept
    @(negedge clk);
    wait_free();
    for (int j = 0; j < 10; j++) begin
      e.x   = rand_state();
      start = 1'b1;
      din   = pl_fwd(e.x);
      if (cyc >= model_free) begin
        e.din = din;
        e.cyc = cyc;
        sb.push_back(e);
        model_free = cyc + LAT + 1;
      end
      @(negedge clk);
    end
    start = 1'b0;

    @(negedge clk);
    wait_free();
    start = 1'b1;
    din   = pl_fwd(rand_state());
    c0    = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < c0 + RST_AT) @(negedge clk);
    resetb = 1'b0;
    @(negedge clk);
    resetb = 1'b1;
    chk_st("midop_reset_out", dout, zero_s);
    chk_int("midop_reset_busy", int'(busy), 0);
    chk_int("midop_reset_done", int'(done), 0);
    model_free = cyc;
    repeat (LAT + 2) @(negedge clk);

    run_op(xv, 1'b1);

    for (int t = 0; t < 50 && sb.size() != 0; t++) @(negedge clk);
    chk_int("scoreboard_drained", sb.size(), 0);
    repeat (3) @(negedge clk);
    chk_st("hold_in_idle", dout, xv);
    chk_int("idle_busy", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
